fetch_unit: RTL

Dual-issue instruction fetch stage: the producer for the decode stage's `inst_a`/`inst_b` pair. Issues 8-byte-aligned requests to instruction memory and buffers returned words in a circular instruction queue. Presents up to two in-order instructions per cycle to decode with a valid/ready handshake. Handles front-end redirects by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
package fetch_pkg;

    typedef logic [31:0] inst_t;
    typedef logic [63:0] fetch_pair_t;

    localparam inst_t       NOP_INST       = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align8(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: up to two pushes and two pops per cycle, flush, head/head+1 read ports.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic [1:0]               wr_n_i,
    input  inst_t                    wr0_i,
    input  inst_t                    wr1_i,
    input  logic [1:0]               rd_n_i,
    output inst_t                    head0_o,
    output inst_t                    head1_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    inst_t         mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_nx_s, wr_ptr_nx_s;

    assign rd_ptr_nx_s = rd_ptr_q + AW'(1'b1);
    assign wr_ptr_nx_s = wr_ptr_q + AW'(1'b1);
    assign head0_o     = mem_q[rd_ptr_q];
    assign head1_o     = mem_q[rd_ptr_nx_s];
    assign count_o     = count_q;

    // Next pointer/count; pointers wrap naturally at DEPTH
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(rd_n_i);
            wr_ptr_d = wr_ptr_q + AW'(wr_n_i);
            count_d  = count_q + (AW+1)'(wr_n_i) - (AW+1)'(rd_n_i);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage writes; contents are only observed through count-gated reads
    always_ff @(posedge clock) begin
        if (!flush_i && (wr_n_i != 2'd0)) begin
            mem_q[wr_ptr_q] <= wr0_i;
        end
        if (!flush_i && (wr_n_i == 2'd2)) begin
            mem_q[wr_ptr_nx_s] <= wr1_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: PC, request credit, skip-tag FIFO, redirect drop logic.
// Optional starvation counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [63:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_a,
    output logic [31:0] inst_b,
    output logic        inst_a_valid,
    output logic        inst_b_valid,
    output logic [31:0] pc_a,
    input  logic        decode_ready,
    output logic [31:0] perf_starve_cnt
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]        fetch_pc_q, fetch_pc_d, pc_a_q, pc_a_d;
    logic [OW-1:0]      out_q, out_d, drop_q, drop_d, tcnt_q, tcnt_d;
    logic [MAX_OUT-1:0] tags_q, tags_d;
    logic [CW-1:0]      count_s;
    logic [31:0]        credit_s;
    logic               req_fire_s, resp_live_s, skip_s;
    logic [1:0]         wr_n_s, rd_n_s;
    inst_t              head0_s, head1_s, wr0_s;
    fetch_pair_t        resp_s;

    assign resp_s      = imem_resp_data;
    // Space for every in-flight response is reserved before the request goes out
    assign credit_s    = 32'(count_s) + (32'(out_q) << 1) + 32'd2;
    assign imem_req_valid = reset_n && !redirect_valid
                         && (32'(out_q) < 32'(MAX_OUT)) && (credit_s <= 32'(DEPTH));
    assign imem_req_addr  = align8(fetch_pc_q);
    assign req_fire_s  = imem_req_valid && imem_req_ready;
    assign resp_live_s = imem_resp_valid && (drop_q == {OW{1'b0}});
    assign skip_s      = tags_q[0];
    assign wr0_s       = skip_s ? resp_s[63:32] : resp_s[31:0];

    // Queue write/read counts; redirect suppresses both
    always_comb begin
        wr_n_s = 2'd0;
        rd_n_s = 2'd0;
        if (redirect_valid) begin
            wr_n_s = 2'd0;
            rd_n_s = 2'd0;
        end else begin
            if (resp_live_s) begin
                wr_n_s = skip_s ? 2'd1 : 2'd2;
            end else begin
                wr_n_s = 2'd0;
            end
            if (decode_ready && (count_s >= CW'(2))) begin
                rd_n_s = 2'd2;
            end else if (decode_ready && (count_s != {CW{1'b0}})) begin
                rd_n_s = 2'd1;
            end else begin
                rd_n_s = 2'd0;
            end
        end
    end

    // PC, outstanding/drop accounting and skip-tag FIFO next state
    always_comb begin
        out_d      = out_q + OW'(req_fire_s) - OW'(imem_resp_valid);
        drop_d     = drop_q;
        tags_d     = tags_q;
        tcnt_d     = tcnt_q;
        pc_a_d     = pc_a_q + {28'd0, rd_n_s, 2'b00};
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            drop_d     = out_d;
            tags_d     = {MAX_OUT{1'b0}};
            tcnt_d     = {OW{1'b0}};
            pc_a_d     = redirect_pc;
            fetch_pc_d = redirect_pc;
        end else begin
            if (imem_resp_valid && (drop_q != {OW{1'b0}})) begin
                drop_d = drop_q - OW'(1'b1);
            end else begin
                drop_d = drop_q;
            end
            if (resp_live_s) begin
                tags_d = tags_q >> 1;
                tcnt_d = tcnt_q - OW'(1'b1);
            end else begin
                tcnt_d = tcnt_q;
            end
            if (req_fire_s) begin
                fetch_pc_d = align8(fetch_pc_q) + 32'd8;
                for (int i = 0; i < MAX_OUT; i++) begin
                    if (OW'(i) == tcnt_d) begin
                        tags_d[i] = fetch_pc_q[2];
                    end else begin
                        tags_d[i] = tags_d[i];
                    end
                end
                tcnt_d = tcnt_d + OW'(1'b1);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            pc_a_q     <= RESET_PC;
            out_q      <= {OW{1'b0}};
            drop_q     <= {OW{1'b0}};
            tcnt_q     <= {OW{1'b0}};
            tags_q     <= {MAX_OUT{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_a_q     <= pc_a_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            tcnt_q     <= tcnt_d;
            tags_q     <= tags_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .flush_i (redirect_valid),
        .wr_n_i  (wr_n_s),
        .wr0_i   (wr0_s),
        .wr1_i   (resp_s[63:32]),
        .rd_n_i  (rd_n_s),
        .head0_o (head0_s),
        .head1_o (head1_s),
        .count_o (count_s)
    );

    assign inst_a_valid = (count_s != {CW{1'b0}});
    assign inst_b_valid = (count_s >= CW'(2));
    assign inst_a       = inst_a_valid ? head0_s : NOP_INST;
    assign inst_b       = inst_b_valid ? head1_s : NOP_INST;
    assign pc_a         = pc_a_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_q;

    // Cycles where decode was ready but nothing could be issued
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_q <= 32'd0;
        end else if (decode_ready && !inst_a_valid && !redirect_valid) begin
            perf_q <= perf_q + 32'd1;
        end else begin
            perf_q <= perf_q;
        end
    end

    assign perf_starve_cnt = perf_q;
`else
    assign perf_starve_cnt = 32'd0;
`endif

endmodule
